spi_sram_burst_master: RTL and testbench



---
 rtl/spi_sram_burst_master_if.sv | 26 ++
 rtl/spi_sram_burst_master.sv | 199 +++++++++++++++++++
 tb/tb_spi_sram_burst_master.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_sram_burst_master_if.sv
// Memory-side request bus between the cache and the SPI SRAM burst master.
// master modport: requester (cache); slave modport: the SPI SRAM master.
interface spi_sram_burst_master_if #(
  parameter int ADDR_W = 24
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_wr;
  logic              mem_rburst;
  logic              mem_wburst;
  logic [7:0]        mem_wdata;
  logic              mem_rdy;
  logic              mem_wdata_ack;
  logic [7:0]        mem_rdata;
  logic              mem_rdata_vld;

  modport master (
    output mem_addr, mem_en, mem_wr, mem_rburst, mem_wburst, mem_wdata,
    input  mem_rdy, mem_wdata_ack, mem_rdata, mem_rdata_vld
  );

  modport slave (
    input  mem_addr, mem_en, mem_wr, mem_rburst, mem_wburst, mem_wdata,
    output mem_rdy, mem_wdata_ack, mem_rdata, mem_rdata_vld
  );
endinterface

// File: rtl/spi_sram_burst_master.sv
// SPI mode-0 master for 23LC-style serial SRAM: single and fixed-length burst
// reads/writes, self-generated SCK (half-period CLK_DIV clk), MSB first.
// Optional macro SPI_SRAM_MODE_INIT_EN: after reset, write the mode register
// (0x01, 0x40 = sequential mode) before the first request is accepted.
//
// state  | meaning
// S_INIT | one clk after reset; optionally starts the mode-register frame
// S_IDLE | mem_rdy=1, waiting for mem_en
// S_CMD  | shifting the 8-bit command
// S_ADDR | shifting ADDR_W address bits
// S_DATA | shifting/receiving data bytes
// S_GAP  | cs_n high for 2*CLK_DIV clk between frames
module spi_sram_burst_master #(
  parameter int ADDR_W    = 24,
  parameter int BURST_LEN = 8,
  parameter int CLK_DIV   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_sram_burst_master_if.slave bus,
  output logic                   cs_n,
  output logic                   sck,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int SH_W  = 8 + ADDR_W;
  localparam int CNT_W = $clog2(BURST_LEN);
  localparam logic [4:0]       HALF_M1  = 5'(CLK_DIV - 1);
  localparam logic [4:0]       GAP_M1   = 5'(2 * CLK_DIV - 1);
  localparam logic [4:0]       ADDR_M1  = 5'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] BURST_M1 = CNT_W'(BURST_LEN - 1);

  if (ADDR_W != 16 && ADDR_W != 24) begin : g_addr_w_check
    $error("spi_sram_burst_master: ADDR_W must be 16 or 24");
  end
  if (BURST_LEN < 2 || BURST_LEN > 64) begin : g_burst_check
    $error("spi_sram_burst_master: BURST_LEN must be 2..64");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
    $error("spi_sram_burst_master: CLK_DIV must be 1..16");
  end

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CMD, S_ADDR, S_DATA, S_GAP} state_t;

  state_t           state, state_n;
  logic [SH_W-1:0]  sh;
  logic [4:0]       tmr;
  logic             ph;
  logic [4:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic             wr_q;
  logic             burst_q;
  logic             init_frame;
  logic [7:0]       wdata_q;
  logic [7:0]       rx;
  logic [7:0]       rdata_q;
  logic             vld_q;
  logic             seg_end;
  logic             rdy;
  logic             ack;

  // last half of the last bit of the current segment (cmd, addr or data byte)
  assign seg_end = (tmr == 5'd0) && ph && (bit_cnt == 5'd0);

  assign sck                = ph;
  assign mosi               = sh[SH_W-1];
  assign bus.mem_rdy        = rdy;
  assign bus.mem_wdata_ack  = ack;
  assign bus.mem_rdata      = rdata_q;
  assign bus.mem_rdata_vld  = vld_q;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_n;
  end

  // next state, ready and write-data acknowledge
  always_comb begin
    state_n = state;
    rdy     = 1'b0;
    ack     = 1'b0;
    case (state)
      S_INIT: begin
`ifdef SPI_SRAM_MODE_INIT_EN
        state_n = S_CMD;
`else
        state_n = S_IDLE;
`endif
      end
      S_IDLE: begin
        rdy = 1'b1;
        ack = bus.mem_en && bus.mem_wr;
        if (bus.mem_en) state_n = S_CMD;
      end
      S_CMD:  if (seg_end) state_n = init_frame ? S_DATA : S_ADDR;
      S_ADDR: if (seg_end) state_n = S_DATA;
      S_DATA: begin
        ack = seg_end && wr_q && (byte_cnt != '0);
        if (seg_end && byte_cnt == '0) state_n = S_GAP;
      end
      S_GAP:  if (tmr == 5'd0) state_n = S_IDLE;
      default: state_n = S_INIT;
    endcase
  end

  // shift engine: SCK phase timer, bit/byte counters, chip select, receive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh         <= '0;
      tmr        <= '0;
      ph         <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      wr_q       <= 1'b0;
      burst_q    <= 1'b0;
      init_frame <= 1'b0;
      wdata_q    <= '0;
      rx         <= '0;
      rdata_q    <= '0;
      vld_q      <= 1'b0;
      cs_n       <= 1'b1;
    end else begin
      vld_q <= 1'b0;
      case (state)
        S_INIT: begin
`ifdef SPI_SRAM_MODE_INIT_EN
          sh         <= {8'h01, 8'h40, {(SH_W-16){1'b0}}};
          cs_n       <= 1'b0;
          tmr        <= HALF_M1;
          ph         <= 1'b0;
          bit_cnt    <= 5'd7;
          byte_cnt   <= '0;
          wr_q       <= 1'b1;
          init_frame <= 1'b1;
`endif
        end
        S_IDLE: begin
          if (bus.mem_en) begin
            sh       <= {(bus.mem_wr ? 8'h02 : 8'h03), bus.mem_addr};
            cs_n     <= 1'b0;
            tmr      <= HALF_M1;
            ph       <= 1'b0;
            bit_cnt  <= 5'd7;
            wr_q     <= bus.mem_wr;
            burst_q  <= bus.mem_wr ? bus.mem_wburst : bus.mem_rburst;
            wdata_q  <= bus.mem_wdata;
          end
        end
        S_CMD, S_ADDR, S_DATA: begin
          if (tmr != 5'd0) begin
            tmr <= tmr - 5'd1;
          end else begin
            tmr <= HALF_M1;
            ph  <= ~ph;
            if (!ph) begin
              rx <= {rx[6:0], miso};
              if (state == S_DATA && !wr_q && bit_cnt == 5'd0) begin
                rdata_q <= {rx[6:0], miso};
                vld_q   <= 1'b1;
              end
            end else begin
              sh      <= sh << 1;
              bit_cnt <= bit_cnt - 5'd1;
              if (bit_cnt == 5'd0) begin
                case (state)
                  S_CMD: bit_cnt <= init_frame ? 5'd7 : ADDR_M1;
                  S_ADDR: begin
                    bit_cnt  <= 5'd7;
                    byte_cnt <= burst_q ? BURST_M1 : '0;
                    if (wr_q) sh[SH_W-1 -: 8] <= wdata_q;
                  end
                  default: begin
                    bit_cnt  <= 5'd7;
                    byte_cnt <= byte_cnt - CNT_W'(1);
                    if (byte_cnt == '0) begin
                      cs_n <= 1'b1;
                      tmr  <= GAP_M1;
                      sh   <= '0;
                    end else if (wr_q) begin
                      sh[SH_W-1 -: 8] <= bus.mem_wdata;
                    end
                  end
                endcase
              end
            end
          end
        end
        S_GAP: begin
          init_frame <= 1'b0;
          if (tmr != 5'd0) tmr <= tmr - 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sram_burst_master.sv
// Bench for spi_sram_burst_master: two instances (CLK_DIV=1 and CLK_DIV=3)
// share one behavioural 23LC-style SRAM model on muxed SPI pins.
module tb_spi_sram_burst_master;

  logic clk  = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;
  always #5 clk = ~clk;

`ifdef SPI_SRAM_MODE_INIT_EN
  localparam int INIT_RDY_CLK = 36;
  localparam int INIT_FRAMES  = 1;
`else
  localparam int INIT_RDY_CLK = 2;
  localparam int INIT_FRAMES  = 0;
`endif

  spi_sram_burst_master_if #(.ADDR_W(24)) bus1();
  spi_sram_burst_master_if #(.ADDR_W(24)) bus3();

  logic        cs1, sck1, mosi1, cs3, sck3, mosi3;
  logic        miso = 1'b0;
  logic        sel3 = 1'b0;
  logic        req_en = 1'b0, req_wr = 1'b0, req_rb = 1'b0, req_wb = 1'b0;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;

  assign bus1.mem_addr   = req_addr;
  assign bus1.mem_en     = req_en & ~sel3;
  assign bus1.mem_wr     = req_wr;
  assign bus1.mem_rburst = req_rb;
  assign bus1.mem_wburst = req_wb;
  assign bus1.mem_wdata  = req_wdata;
  assign bus3.mem_addr   = req_addr;
  assign bus3.mem_en     = req_en & sel3;
  assign bus3.mem_wr     = req_wr;
  assign bus3.mem_rburst = req_rb;
  assign bus3.mem_wburst = req_wb;
  assign bus3.mem_wdata  = req_wdata;

  logic       m_rdy, m_ack, m_vld, m_cs;
  logic [7:0] m_rdata;
  assign m_rdy   = sel3 ? bus3.mem_rdy       : bus1.mem_rdy;
  assign m_ack   = sel3 ? bus3.mem_wdata_ack : bus1.mem_wdata_ack;
  assign m_vld   = sel3 ? bus3.mem_rdata_vld : bus1.mem_rdata_vld;
  assign m_rdata = sel3 ? bus3.mem_rdata     : bus1.mem_rdata;
  assign m_cs    = sel3 ? cs3 : cs1;

  spi_sram_burst_master #(.ADDR_W(24), .BURST_LEN(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1),
    .cs_n(cs1), .sck(sck1), .mosi(mosi1), .miso(miso)
  );

  spi_sram_burst_master #(.ADDR_W(24), .BURST_LEN(8), .CLK_DIV(3)) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3),
    .cs_n(cs3), .sck(sck3), .mosi(mosi3), .miso(miso)
  );

  // SRAM model: 128 KiB, sequential mode, wraps at top of array
  logic       cs_m, sck_m, mosi_m;
  assign cs_m   = cs1 & cs3;
  assign sck_m  = sck1 | sck3;
  assign mosi_m = cs1 ? mosi3 : mosi1;

  logic [7:0]  sram [0:131071];
  int          frames = 0;
  int          seen_frame = 0;
  int          nbit = 0;
  logic [7:0]  m_cmd = '0, m_mode = '0, m_wbyte = '0, rd_byte;
  logic [23:0] m_addr = '0;

  always @(negedge cs_m) frames++;

  always @(posedge sck_m) begin
    if (!cs_m) begin
      if (seen_frame != frames) begin
        nbit = 0;
        seen_frame = frames;
      end
      if (nbit < 8) m_cmd = {m_cmd[6:0], mosi_m};
      else if (m_cmd == 8'h01) m_mode = {m_mode[6:0], mosi_m};
      else if (nbit < 32) m_addr = {m_addr[22:0], mosi_m};
      else if (m_cmd == 8'h02) begin
        m_wbyte = {m_wbyte[6:0], mosi_m};
        if ((nbit - 32) % 8 == 7)
          sram[(int'(m_addr) + (nbit - 32) / 8) & 32'h1FFFF] = m_wbyte;
      end
      nbit++;
    end
  end

  always @(negedge sck_m) begin
    if (!cs_m && m_cmd == 8'h03 && nbit >= 32) begin
      rd_byte = sram[(int'(m_addr) + (nbit - 32) / 8) & 32'h1FFFF];
      miso = rd_byte[7 - ((nbit - 32) % 8)];
    end
  end

  // SCK period of the divided instance, in clk cycles
  time last_r3 = 0;
  int  per3 = 0;
  always @(posedge sck3) begin
    if (last_r3 != 0) per3 = int'(($time - last_r3) / 10);
    last_r3 = $time;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] wbuf [0:7];
  int         n_ack, ack0, cs_low, rdy_k;
  logic [7:0] vld_q[$];
  int         vcyc_q[$];

  task automatic xact(input bit s3, input logic [23:0] a, input bit wr,
                      input bit rb, input bit wb, input bit poke);
    int  widx;
    bit  ackd;
    n_ack = 0; ack0 = 0; cs_low = 0; rdy_k = -1;
    vld_q.delete(); vcyc_q.delete();
    sel3 = s3;
    @(negedge clk);
    req_addr = a; req_wr = wr; req_rb = rb; req_wb = wb;
    widx = 0; req_wdata = wbuf[0]; req_en = 1'b1;
    #1;
    ackd = m_ack;
    if (ackd) begin n_ack++; ack0 = 1; end
    for (int k = 1; k < 4000; k++) begin
      @(posedge clk); #1;
      req_en = poke && (k == 10);
      if (ackd) begin widx++; req_wdata = wbuf[widx % 8]; end
      ackd = m_ack;
      if (ackd) n_ack++;
      if (m_vld) begin vld_q.push_back(m_rdata); vcyc_q.push_back(k); end
      if (!m_cs) cs_low++;
      if (m_rdy) begin rdy_k = k; break; end
    end
    req_en = 1'b0;
    check("xact_done", 32'(rdy_k >= 0), 32'd1);
  endtask

  task automatic wait_rdy(input string tag, input int maxc);
    int e;
    e = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(posedge clk); #1;
      if (m_rdy) begin e = k; break; end
    end
    check(tag, 32'(e >= 0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, bad, fr0;
    for (int i = 0; i < 8; i++) wbuf[i] = 8'h10 + 8'(i);

    // reset values
    repeat (3) @(posedge clk); #1;
    check("rst_cs_n",  32'(cs1), 32'd1);
    check("rst_sck",   32'(sck1), 32'd0);
    check("rst_mosi",  32'(mosi1), 32'd0);
    check("rst_rdy",   32'(bus1.mem_rdy), 32'd0);
    check("rst_vld",   32'(bus1.mem_rdata_vld), 32'd0);
    check("rst_rdata", 32'(bus1.mem_rdata), 32'd0);

    // reset release: INIT, then ready; requests during INIT ignored
    sel3 = 1'b0;
    @(negedge clk);
    rst1 = 1'b0;
`ifdef SPI_SRAM_MODE_INIT_EN
    req_en = 1'b1;
`endif
    #1;
    check("init_rdy_clk1", 32'(m_rdy), 32'd0);
    edges = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 20) req_en = 1'b0;
      if (m_rdy) begin edges = k; break; end
    end
    req_en = 1'b0;
    check("init_rdy_clk", 32'(edges + 1), 32'(INIT_RDY_CLK));
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (cs1 !== 1'b1 || sck1 !== 1'b0 || m_rdy !== 1'b1) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    check("init_frames", 32'(frames), 32'(INIT_FRAMES));
`ifdef SPI_SRAM_MODE_INIT_EN
    check("init_cmd", 32'(m_cmd), 32'h01);
    check("init_mode", 32'(m_mode), 32'h40);
`endif

    // bring up the divided instance
    @(negedge clk);
    rst3 = 1'b0;
    sel3 = 1'b1;
    wait_rdy("dut3_ready", 300);
    sel3 = 1'b0;

    // single write of 0xA5 to 0x012345
    wbuf[0] = 8'hA5;
    xact(0, 24'h012345, 1, 0, 0, 0);
    check("swr_acks", 32'(n_ack), 32'd1);
    check("swr_cmd", 32'(m_cmd), 32'h02);
    check("swr_mem", 32'(sram[32'h12345]), 32'hA5);
    wbuf[0] = 8'h10;

    // single read, with a stray mem_en while busy
    fr0 = frames;
    xact(0, 24'h012345, 0, 0, 0, 1);
    check("srd_cmd", 32'(m_cmd), 32'h03);
    check("srd_addr", 32'(m_addr), 32'h012345);
    check("srd_vld_cnt", 32'(vld_q.size()), 32'd1);
    if (vld_q.size() > 0) check("srd_data", 32'(vld_q[0]), 32'hA5);
    check("srd_rdy_clk", 32'(rdy_k + 1), 32'd84);
    check("srd_cs_low", 32'(cs_low), 32'd80);
    check("srd_frames", 32'(frames - fr0), 32'd1);

    // write burst across 0xFFFF
    xact(0, 24'h00FFFC, 1, 0, 1, 0);
    check("wb_acks", 32'(n_ack), 32'd8);
    check("wb_ack0", 32'(ack0), 32'd1);
    for (int i = 0; i < 8; i++)
      check($sformatf("wb_mem%0d", i), 32'(sram[32'hFFFC + i]), 32'h10 + 32'(i));

    // burst flag on the wrong direction -> single access
    wbuf[0] = 8'h77;
    xact(0, 24'h000200, 1, 1, 0, 0);
    check("wrong_wr_acks", 32'(n_ack), 32'd1);
    check("wrong_wr_mem", 32'(sram[32'h200]), 32'h77);
    wbuf[0] = 8'h10;
    xact(0, 24'h012345, 0, 0, 1, 0);
    check("wrong_rd_vld_cnt", 32'(vld_q.size()), 32'd1);
    if (vld_q.size() > 0) check("wrong_rd_data", 32'(vld_q[0]), 32'hA5);

    // read burst, CLK_DIV=3
    xact(1, 24'h00FFFC, 0, 1, 0, 0);
    check("rb3_vld_cnt", 32'(vld_q.size()), 32'd8);
    for (int i = 0; i < vld_q.size(); i++)
      check($sformatf("rb3_data%0d", i), 32'(vld_q[i]), 32'h10 + 32'(i));
    for (int i = 1; i < vcyc_q.size(); i++)
      check($sformatf("rb3_gap%0d", i), 32'(vcyc_q[i] - vcyc_q[i-1]), 32'd48);
    check("rb3_sck_period", 32'(per3), 32'd6);
    sel3 = 1'b0;

    // reset in the middle of a write burst
    @(negedge clk);
    req_addr = 24'h000300; req_wr = 1'b1; req_wb = 1'b1; req_rb = 1'b0;
    req_en = 1'b1;
    @(posedge clk); #1;
    req_en = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    check("abort_pre_cs", 32'(cs1), 32'd0);
    rst1 = 1'b1;
    #1;
    check("abort_cs_n", 32'(cs1), 32'd1);
    check("abort_sck", 32'(sck1), 32'd0);
    check("abort_rdy", 32'(bus1.mem_rdy), 32'd0);
    check("abort_vld", 32'(bus1.mem_rdata_vld), 32'd0);
    @(negedge clk);
    rst1 = 1'b0;
    req_wr = 1'b0; req_wb = 1'b0;
    wait_rdy("abort_ready", 200);
    xact(0, 24'h012345, 0, 0, 0, 0);
    check("post_abort_vld_cnt", 32'(vld_q.size()), 32'd1);
    if (vld_q.size() > 0) check("post_abort_data", 32'(vld_q[0]), 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
